// File: rtl/flag_ctrl.sv
// Condition-code controller: CCR commit through per-op masks, jump resolution,
// interrupt flag save/restore stack. Optional FLAG_CLEAR_ON_JUMP_EN: taken jumps clear the tested flag.
module flag_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic [4:0] ex_op,
   input  logic [3:0] ex_flags,
   input  logic       int_req,
   output logic [3:0] ccr,
   output logic       br_valid,
   output logic       br_taken,
   output logic       stall,
   output logic       int_ack,
   output logic [3:0] int_depth,
   output logic       stack_err
);

   // state | meaning
   // IDLE  | ops accepted, interrupt requests sampled
   // SAVE  | stall, push ccr onto the save stack
   // ACK   | stall, acknowledge the interrupt
   typedef enum logic [1:0] {S_IDLE, S_SAVE, S_ACK} state_t;

   localparam logic [4:0] OP_SETC = 5'd1;
   localparam logic [4:0] OP_CLRC = 5'd2;
   localparam logic [4:0] OP_NOT  = 5'd3;
   localparam logic [4:0] OP_INC  = 5'd4;
   localparam logic [4:0] OP_DEC  = 5'd5;
   localparam logic [4:0] OP_ADD  = 5'd9;
   localparam logic [4:0] OP_SUB  = 5'd10;
   localparam logic [4:0] OP_AND  = 5'd11;
   localparam logic [4:0] OP_OR   = 5'd12;
   localparam logic [4:0] OP_SHL  = 5'd13;
   localparam logic [4:0] OP_SHR  = 5'd14;
   localparam logic [4:0] OP_JZ   = 5'd20;
   localparam logic [4:0] OP_JN   = 5'd21;
   localparam logic [4:0] OP_JC   = 5'd22;
   localparam logic [4:0] OP_RETI = 5'd26;

   state_t     state;
   logic [3:0] stack [DEPTH];
   logic [3:0] upd_mask;
   logic [3:0] ccr_nxt;
   logic [3:0] pop_val;
   logic       is_jump;
   logic       jump_cond;

   always_comb begin
      upd_mask  = 4'b0000;
      ccr_nxt   = ccr;
      is_jump   = 1'b0;
      jump_cond = 1'b0;
      pop_val   = 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
         if (int_depth == 4'(i + 1)) pop_val = stack[i];
      end
      case (ex_op)
         OP_NOT, OP_INC, OP_DEC, OP_AND, OP_OR: upd_mask = 4'b0110;
         OP_ADD:                                upd_mask = 4'b1111;
         OP_SUB:                                upd_mask = 4'b1110;
         OP_SHL, OP_SHR:                        upd_mask = 4'b0001;
         default:                               upd_mask = 4'b0000;
      endcase
      ccr_nxt = (ccr & ~upd_mask) | (ex_flags & upd_mask);
      case (ex_op)
         OP_SETC: ccr_nxt[0] = 1'b1;
         OP_CLRC: ccr_nxt[0] = 1'b0;
         OP_JZ: begin
            is_jump   = 1'b1;
            jump_cond = ccr[1];
`ifdef FLAG_CLEAR_ON_JUMP_EN
            if (ccr[1]) ccr_nxt[1] = 1'b0;
`endif
         end
         OP_JN: begin
            is_jump   = 1'b1;
            jump_cond = ccr[2];
`ifdef FLAG_CLEAR_ON_JUMP_EN
            if (ccr[2]) ccr_nxt[2] = 1'b0;
`endif
         end
         OP_JC: begin
            is_jump   = 1'b1;
            jump_cond = ccr[0];
`ifdef FLAG_CLEAR_ON_JUMP_EN
            if (ccr[0]) ccr_nxt[0] = 1'b0;
`endif
         end
         OP_RETI: begin
            if (int_depth != 4'd0) ccr_nxt = pop_val;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ccr       <= 4'b0000;
         br_valid  <= 1'b0;
         br_taken  <= 1'b0;
         stall     <= 1'b0;
         int_ack   <= 1'b0;
         int_depth <= 4'd0;
         stack_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stack[i] <= 4'b0000;
      end else begin
         br_valid  <= 1'b0;
         br_taken  <= 1'b0;
         stack_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ex_valid) begin
                  ccr      <= ccr_nxt;
                  br_valid <= is_jump;
                  br_taken <= is_jump & jump_cond;
                  if (ex_op == OP_RETI) begin
                     if (int_depth == 4'd0) stack_err <= 1'b1;
                     else                   int_depth <= int_depth - 4'd1;
                  end
               end
               // a full stack leaves the request pending until a RETI frees a slot
               if (int_req && (int_depth < 4'(DEPTH))) begin
                  state <= S_SAVE;
                  stall <= 1'b1;
               end
            end
            S_SAVE: begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (int_depth == 4'(i)) stack[i] <= ccr;
               end
               int_depth <= int_depth + 4'd1;
               int_ack   <= 1'b1;
               state     <= S_ACK;
            end
            S_ACK: begin
               int_ack <= 1'b0;
               stall   <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               int_ack <= 1'b0;
               stall   <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
